// File: rtl/display_decoder.sv
// display_decoder: captures a sign-magnitude result on the rising edge of complete,
// converts it to 5 BCD digits with a 15-step double-dabble, and scans a 6-position
// seven-segment display. Optional macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module display_decoder #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        complete,
    input  logic [15:0] value,
    output logic        busy,
    output logic        valid,
    output logic        sign,
    output logic [19:0] bcd,
    output logic [6:0]  seg,
    output logic [5:0]  an
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(SCAN_DIV - 1);

    state_t        state;
    logic          complete_q;
    logic [34:0]   shreg;
    logic [3:0]    iter;
    logic          sign_latched;
    logic [34:0]   shreg_next;
    logic          start;

    logic [PW-1:0] prescale;
    logic [2:0]    idx;
    logic [2:0]    idx_next;
    logic [3:0]    nibble;
    logic          blank;
    logic [6:0]    seg_next;

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left by one.
    function automatic logic [34:0] dd_step(input logic [34:0] r);
        logic [34:0] t;
        t = r;
        for (int k = 0; k < 5; k++) begin
            if (t[15+4*k +: 4] >= 4'd5)
                t[15+4*k +: 4] = t[15+4*k +: 4] + 4'd3;
        end
        return {t[33:0], 1'b0};
    endfunction

    // Decimal digit to active-high {g,f,e,d,c,b,a}; non-decimal codes stay dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Start condition and next shift-register contents.
    always_comb begin
        start      = complete && !complete_q && (state == IDLE);
        shreg_next = dd_step(shreg);
    end

    // Conversion FSM: capture on a rising complete edge, 15 shift steps, publish the result.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            complete_q   <= 1'b0;
            shreg        <= '0;
            iter         <= '0;
            sign_latched <= 1'b0;
            busy         <= 1'b0;
            valid        <= 1'b0;
            sign         <= 1'b0;
            bcd          <= '0;
        end else begin
            complete_q <= complete;
            valid      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg        <= {20'd0, value[14:0]};
                        // Negative zero is folded into a positive result here.
                        sign_latched <= value[15] && (value[14:0] != 15'd0);
                        iter         <= 4'd0;
                        busy         <= 1'b1;
                        state        <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg <= shreg_next;
                    iter  <= iter + 4'd1;
                    if (iter == 4'd14) begin
                        bcd   <= shreg_next[34:15];
                        sign  <= sign_latched;
                        valid <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Next scan position: advance only when the prescaler wraps.
    always_comb begin
        idx_next = idx;
        if (prescale == PRESCALE_LAST)
            idx_next = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end

    // Segment pattern for the position that will be lit after this edge.
    always_comb begin
        nibble = 4'd0;
        blank  = 1'b0;
        case (idx_next)
            3'd0: nibble = bcd[3:0];
            3'd1: nibble = bcd[7:4];
            3'd2: nibble = bcd[11:8];
            3'd3: nibble = bcd[15:12];
            3'd4: nibble = bcd[19:16];
            default: nibble = 4'd0;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is blank when it and every more significant digit are zero.
        case (idx_next)
            3'd1: blank = (bcd[19:4]  == 16'd0);
            3'd2: blank = (bcd[19:8]  == 12'd0);
            3'd3: blank = (bcd[19:12] == 8'd0);
            3'd4: blank = (bcd[19:16] == 4'd0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
        if (idx_next == 3'd5)
            seg_next = sign ? 7'b1000000 : 7'b0000000;
        else if (blank)
            seg_next = 7'b0000000;
        else
            seg_next = seg_decode(nibble);
    end

    // Display scan: prescaler, position index, and registered seg/an.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            prescale <= '0;
            idx      <= 3'd0;
            an       <= 6'b000001;
            seg      <= 7'b0111111;
        end else begin
            prescale <= (prescale == PRESCALE_LAST) ? '0 : prescale + 1'b1;
            idx      <= idx_next;
            an       <= 6'b000001 << idx_next;
            seg      <= seg_next;
        end
    end

endmodule
